// File: rtl/wb_retire_stage.sv
// Multi-lane writeback/retire stage with one-entry skid buffer and fetch redirect.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_retire_stage #(
    parameter int LANES  = 2,
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_rd_we,
    input  logic [LANES*REG_AW-1:0] in_rd_addr,
    input  logic [LANES*XLEN-1:0]   in_rd_data,
    input  logic [LANES-1:0]        in_redirect,
    input  logic [LANES*PC_W-1:0]   in_target,
    output logic [LANES-1:0]        rf_we,
    output logic [LANES*REG_AW-1:0] rf_waddr,
    output logic [LANES*XLEN-1:0]   rf_wdata,
    output logic                    if_redirect,
    output logic [PC_W-1:0]         if_target,
    output logic [31:0]             retire_cnt
);

    logic                    skid_full;
    logic [LANES-1:0]        sk_valid;
    logic [LANES-1:0]        sk_we;
    logic [LANES-1:0]        sk_redir;
    logic [LANES*REG_AW-1:0] sk_addr;
    logic [LANES*XLEN-1:0]   sk_data;
    logic [LANES*PC_W-1:0]   sk_target;

    logic [LANES-1:0]        g_valid;
    logic [LANES-1:0]        g_we;
    logic [LANES-1:0]        g_redir;
    logic [LANES*REG_AW-1:0] g_addr;
    logic [LANES*XLEN-1:0]   g_data;
    logic [LANES*PC_W-1:0]   g_target;

    logic [LANES-1:0] v;
    logic [LANES-1:0] we_raw;
    logic [LANES-1:0] we_fin;
    logic             hit;
    logic [PC_W-1:0]  tgt;
    logic             accept;
    logic             load;

    assign in_ready = ~skid_full;
    assign accept   = (|in_valid) & ~skid_full & ~flush;
    assign load     = ~flush & ~stall & (skid_full | accept);

    // A full skid always holds the oldest group, so it drains first.
    assign g_valid  = skid_full ? sk_valid  : in_valid;
    assign g_we     = skid_full ? sk_we     : in_rd_we;
    assign g_redir  = skid_full ? sk_redir  : in_redirect;
    assign g_addr   = skid_full ? sk_addr   : in_rd_addr;
    assign g_data   = skid_full ? sk_data   : in_rd_data;
    assign g_target = skid_full ? sk_target : in_target;

    always_comb begin
        v      = '0;
        we_raw = '0;
        hit    = 1'b0;
        tgt    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (g_valid[i] && !hit) begin
                v[i] = 1'b1;
                if (g_redir[i]) begin
                    hit = 1'b1;
                    tgt = g_target[i*PC_W +: PC_W];
                end
            end
        end
        for (int i = 0; i < LANES; i++) begin
            we_raw[i] = v[i] & g_we[i] &
                        (g_addr[i*REG_AW +: REG_AW] != '0);
        end
        we_fin = we_raw;
        // Youngest writer of an address wins within the group.
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (we_raw[j] &&
                    g_addr[j*REG_AW +: REG_AW] == g_addr[i*REG_AW +: REG_AW])
                    we_fin[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_full   <= 1'b0;
            sk_valid    <= '0;
            sk_we       <= '0;
            sk_redir    <= '0;
            sk_addr     <= '0;
            sk_data     <= '0;
            sk_target   <= '0;
            rf_we       <= '0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            if_redirect <= 1'b0;
            if_target   <= '0;
        end else if (flush) begin
            skid_full   <= 1'b0;
            rf_we       <= '0;
            if_redirect <= 1'b0;
        end else if (stall) begin
            rf_we       <= '0;
            if_redirect <= 1'b0;
            if (accept) begin
                skid_full <= 1'b1;
                sk_valid  <= in_valid;
                sk_we     <= in_rd_we;
                sk_redir  <= in_redirect;
                sk_addr   <= in_rd_addr;
                sk_data   <= in_rd_data;
                sk_target <= in_target;
            end
        end else if (load) begin
            skid_full   <= 1'b0;
            rf_we       <= we_fin;
            rf_waddr    <= g_addr;
            rf_wdata    <= g_data;
            if_redirect <= hit;
            if (hit)
                if_target <= tgt;
        end else begin
            rf_we       <= '0;
            if_redirect <= 1'b0;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] cnt_q;
    logic [31:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++)
            pop = pop + {31'd0, v[i]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (load)
            cnt_q <= cnt_q + pop;
    end

    assign retire_cnt = cnt_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed scoreboard bench for wb_retire_stage (LANES=2).
// Counter expectations follow WB_RETIRE_CNT_EN.
module tb_wb_retire_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [1:0]  in_valid;
    logic        in_ready;
    logic [1:0]  in_rd_we;
    logic [9:0]  in_rd_addr;
    logic [63:0] in_rd_data;
    logic [1:0]  in_redirect;
    logic [63:0] in_target;
    logic [1:0]  rf_we;
    logic [9:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        if_redirect;
    logic [31:0] if_target;
    logic [31:0] retire_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        rd;
        logic [31:0] tg;
        logic        rdy;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    logic [31:0] exp_cnt = 0;

    wb_retire_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd_we   (in_rd_we),
        .in_rd_addr (in_rd_addr),
        .in_rd_data (in_rd_data),
        .in_redirect(in_redirect),
        .in_target  (in_target),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .if_redirect(if_redirect),
        .if_target  (if_target),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [1:0] v, input logic [1:0] we,
                       input logic [1:0] rdr,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [31:0] t0, input logic [31:0] t1,
                       input logic st, input logic fl);
        in_valid    = v;
        in_rd_we    = we;
        in_redirect = rdr;
        in_rd_addr  = {a1, a0};
        in_rd_data  = {d1, d0};
        in_target   = {t1, t0};
        stall       = st;
        flush       = fl;
    endtask

    task automatic idle(input logic st, input logic fl);
        drv(2'b00, 2'b00, 2'b00, 5'd0, 0, 5'd0, 0, 0, 0, st, fl);
    endtask

    task automatic expect_out(input logic [1:0] we,
                              input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic rd, input logic [31:0] tg,
                              input logic rdy, input int n);
        exp_t e;
`ifdef WB_RETIRE_CNT_EN
        exp_cnt = exp_cnt + n;
`endif
        e.we = we; e.a0 = a0; e.d0 = d0; e.a1 = a1; e.d1 = d1;
        e.rd = rd; e.tg = tg; e.rdy = rdy; e.cnt = exp_cnt;
        q.push_back(e);
    endtask

    task automatic bubble(input logic rdy);
        expect_out(2'b00, 5'd0, 0, 5'd0, 0, 1'b0, 0, rdy, 0);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        total++;
        assert (q.size() > 0) else begin
            bad++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_we"},  64'(rf_we), 64'(e.we));
            chk({tag, "_rd"},  64'(if_redirect), 64'(e.rd));
            chk({tag, "_rdy"}, 64'(in_ready), 64'(e.rdy));
            chk({tag, "_cnt"}, 64'(retire_cnt), 64'(e.cnt));
            if (e.we[0]) begin
                chk({tag, "_a0"}, 64'(rf_waddr[4:0]), 64'(e.a0));
                chk({tag, "_d0"}, 64'(rf_wdata[31:0]), 64'(e.d0));
            end
            if (e.we[1]) begin
                chk({tag, "_a1"}, 64'(rf_waddr[9:5]), 64'(e.a1));
                chk({tag, "_d1"}, 64'(rf_wdata[63:32]), 64'(e.d1));
            end
            if (e.rd)
                chk({tag, "_tg"}, 64'(if_target), 64'(e.tg));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle(1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_we", 64'(rf_we), 0);
        chk("rst_addr", 64'(rf_waddr), 0);
        chk("rst_data", rf_wdata, 0);
        chk("rst_redir", 64'(if_redirect), 0);
        chk("rst_tgt", 64'(if_target), 0);
        chk("rst_cnt", 64'(retire_cnt), 0);
        chk("rst_ready", 64'(in_ready), 1);
        rst_n = 1'b1;

        drv(2'b11, 2'b11, 2'b00, 5'd5, 32'h11, 5'd6, 32'h22, 0, 0, 0, 0);
        expect_out(2'b11, 5'd5, 32'h11, 5'd6, 32'h22, 0, 0, 1, 2);
        tick("two_wr");

        drv(2'b11, 2'b10, 2'b01, 5'd0, 0, 5'd7, 32'h77, 32'h100, 0, 0, 0);
        expect_out(2'b00, 5'd0, 0, 5'd7, 0, 1, 32'h100, 1, 1);
        tick("redir0");

        idle(1'b0, 1'b0);
        bubble(1'b1);
        tick("redir_pulse");

        drv(2'b11, 2'b11, 2'b00, 5'd9, 32'hA, 5'd9, 32'hB, 0, 0, 0, 0);
        expect_out(2'b10, 5'd9, 0, 5'd9, 32'hB, 0, 0, 1, 2);
        tick("same_addr");

        drv(2'b11, 2'b11, 2'b00, 5'd0, 32'h5, 5'd3, 32'h33, 0, 0, 0, 0);
        expect_out(2'b10, 5'd0, 0, 5'd3, 32'h33, 0, 0, 1, 2);
        tick("x0_lane");

        drv(2'b11, 2'b11, 2'b00, 5'd10, 32'h55, 5'd11, 32'h66, 0, 0, 1, 0);
        bubble(1'b0);
        tick("stall_acc");

        idle(1'b1, 1'b0);
        bubble(1'b0);
        tick("stall_hold");

        drv(2'b11, 2'b11, 2'b00, 5'd20, 32'hDE, 5'd21, 32'hAD, 0, 0, 0, 0);
        expect_out(2'b11, 5'd10, 32'h55, 5'd11, 32'h66, 0, 0, 1, 2);
        tick("drain");

        idle(1'b0, 1'b0);
        bubble(1'b1);
        tick("drain_once");

        drv(2'b11, 2'b01, 2'b10, 5'd12, 32'hC0, 5'd0, 0, 0, 32'h200, 1, 0);
        bubble(1'b0);
        tick("stall_redir");

        idle(1'b0, 1'b0);
        expect_out(2'b01, 5'd12, 32'hC0, 5'd0, 0, 1, 32'h200, 1, 2);
        tick("redir_drain");

        idle(1'b0, 1'b0);
        bubble(1'b1);
        tick("redir_once");

        drv(2'b01, 2'b01, 2'b00, 5'd13, 32'h13, 5'd0, 0, 0, 0, 1, 0);
        bubble(1'b0);
        tick("skid_fill");

        drv(2'b11, 2'b11, 2'b00, 5'd14, 32'h14, 5'd15, 32'h15, 0, 0, 0, 1);
        bubble(1'b1);
        tick("flush");

        idle(1'b0, 1'b0);
        bubble(1'b1);
        tick("flush_gone");

        drv(2'b11, 2'b11, 2'b01, 5'd16, 32'h16, 5'd17, 32'h17, 32'h300, 0, 1, 1);
        bubble(1'b1);
        tick("flush_prio");

        drv(2'b11, 2'b11, 2'b00, 5'd18, 32'h18, 5'd19, 32'h19, 0, 0, 1, 0);
        bubble(1'b0);
        tick("pre_rst");

        rst_n = 1'b0;
        idle(1'b1, 1'b0);
        exp_cnt = 0;
        bubble(1'b1);
        tick("rst_stall");
        chk("rst_stall_addr", 64'(rf_waddr), 0);
        chk("rst_stall_data", rf_wdata, 0);
        rst_n = 1'b1;

        idle(1'b0, 1'b0);
        bubble(1'b1);
        tick("post_rst");

        drv(2'b11, 2'b11, 2'b00, 5'd1, 32'hF1, 5'd2, 32'hF2, 0, 0, 0, 0);
        expect_out(2'b11, 5'd1, 32'hF1, 5'd2, 32'hF2, 0, 0, 1, 2);
        tick("post_rst_wr");

        idle(1'b0, 1'b0);
        chk("queue_empty", 64'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
